// File: rtl/fp_mac_rr_sched.sv
// rtl/fp_mac_rr_sched.sv - round-robin scheduler sharing one fp_mac pipeline between dot-product streams
`timescale 1ns/1ps
module fp_mac_rr_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MAC_LAT = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NREQ-1:0]     REQ_VALID,
    output logic [NREQ-1:0]     REQ_READY,
    input  logic [16*NREQ-1:0]  REQ_A,
    input  logic [16*NREQ-1:0]  REQ_B,
    input  logic [NREQ-1:0]     REQ_LAST,
    output logic [15:0]         MAC_A,
    output logic [15:0]         MAC_B,
    output logic [31:0]         MAC_C,
    input  logic [31:0]         MAC_Y,
    output logic                RES_VALID,
    output logic [IDW-1:0]      RES_ID,
    output logic [31:0]         RES_DATA,
    output logic                BUSY
);
    localparam int AW = $clog2(16 * NREQ);

    logic [MAC_LAT-1:0] tag_v;
    logic [MAC_LAT-1:0] tag_last;
    logic [IDW-1:0]     tag_id [MAC_LAT];

    logic [NREQ-1:0]    inflight;
    logic [NREQ-1:0]    first;
    logic [31:0]        acc [NREQ];
    logic [IDW-1:0]     rr_ptr;

    logic               ret_v;
    logic               ret_last;
    logic [IDW-1:0]     ret_id;
    logic [NREQ-1:0]    retiring;
    logic [NREQ-1:0]    eligible;

    logic               gnt_v;
    logic [IDW-1:0]     gnt_id;
    logic [IDW-1:0]     cand;
    logic [AW-1:0]      lane_base;

    assign ret_v    = tag_v[MAC_LAT-1];
    assign ret_last = tag_last[MAC_LAT-1];
    assign ret_id   = tag_id[MAC_LAT-1];
    assign BUSY     = |tag_v;

    // A requester whose element retires this cycle may issue again in the same cycle.
    always_comb begin
        retiring = '0;
        eligible = '0;
        for (int r = 0; r < NREQ; r++) begin
            retiring[r] = ret_v && (ret_id == IDW'(r));
            eligible[r] = REQ_VALID[r] && (!inflight[r] || retiring[r]);
        end
    end

    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = '0;
        cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % NREQ);
            if (!gnt_v && eligible[cand]) begin
                gnt_v  = 1'b1;
                gnt_id = cand;
            end
        end
        if (RESET) begin
            gnt_v  = 1'b0;
            gnt_id = '0;
        end
    end

    // A last element retiring for the granted requester starts a fresh job, hence C = 0.
    always_comb begin
        REQ_READY = '0;
        MAC_A     = '0;
        MAC_B     = '0;
        MAC_C     = '0;
        lane_base = AW'(gnt_id) << 4;
        if (gnt_v) begin
            REQ_READY[gnt_id] = 1'b1;
            MAC_A = REQ_A[lane_base +: 16];
            MAC_B = REQ_B[lane_base +: 16];
            if (first[gnt_id] || (retiring[gnt_id] && ret_last)) begin
                MAC_C = '0;
            end else if (retiring[gnt_id]) begin
                MAC_C = MAC_Y;
            end else begin
                MAC_C = acc[gnt_id];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_v     <= '0;
            tag_last  <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                tag_id[i] <= '0;
            end
            inflight  <= '0;
            first     <= '1;
            for (int r = 0; r < NREQ; r++) begin
                acc[r] <= '0;
            end
            rr_ptr    <= IDW'(NREQ - 1);
            RES_VALID <= 1'b0;
            RES_ID    <= '0;
            RES_DATA  <= '0;
        end else begin
            tag_v     <= {tag_v[MAC_LAT-2:0], gnt_v};
            tag_last  <= {tag_last[MAC_LAT-2:0], gnt_v && REQ_LAST[gnt_id]};
            tag_id[0] <= gnt_id;
            for (int i = 1; i < MAC_LAT; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
            if (ret_v) begin
                acc[ret_id]      <= MAC_Y;
                inflight[ret_id] <= 1'b0;
                first[ret_id]    <= ret_last;
            end
            // Issue updates come last so a same-cycle re-issue wins over the retire.
            if (gnt_v) begin
                inflight[gnt_id] <= 1'b1;
                first[gnt_id]    <= 1'b0;
                rr_ptr           <= gnt_id;
            end
            RES_VALID <= ret_v && ret_last;
            if (ret_v && ret_last) begin
                RES_ID   <= ret_id;
                RES_DATA <= MAC_Y;
            end
        end
    end
endmodule

// File: tb/tb_fp_mac_rr_sched.sv
// tb/tb_fp_mac_rr_sched.sv - randomized self-checking bench for fp_mac_rr_sched
`timescale 1ns/1ps
module tb_fp_mac_rr_sched;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int MAC_LAT = 6;

    logic                clk = 1'b0;
    logic                RESET;
    logic [NREQ-1:0]     REQ_VALID;
    logic [NREQ-1:0]     REQ_READY;
    logic [16*NREQ-1:0]  REQ_A;
    logic [16*NREQ-1:0]  REQ_B;
    logic [NREQ-1:0]     REQ_LAST;
    logic [15:0]         MAC_A;
    logic [15:0]         MAC_B;
    logic [31:0]         MAC_C;
    logic [31:0]         MAC_Y;
    logic                RES_VALID;
    logic [IDW-1:0]      RES_ID;
    logic [31:0]         RES_DATA;
    logic                BUSY;

    always #5 clk = ~clk;

    fp_mac_rr_sched #(.NREQ(NREQ), .IDW(IDW), .MAC_LAT(MAC_LAT)) dut (
        .CLK(clk), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_LAST(REQ_LAST),
        .MAC_A(MAC_A), .MAC_B(MAC_B), .MAC_C(MAC_C), .MAC_Y(MAC_Y),
        .RES_VALID(RES_VALID), .RES_ID(RES_ID), .RES_DATA(RES_DATA),
        .BUSY(BUSY)
    );

    function automatic real pow2(input int e);
        real v;
        v = 1.0;
        if (e >= 0) repeat (e) v = v * 2.0;
        else repeat (-e) v = v / 2.0;
        return v;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) return 0.0;
        v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -v : v;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        real v;
        if (f[30:23] == 8'd0) return 0.0;
        v = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        real m;
        int e;
        logic [7:0] be;
        logic [22:0] fr;
        if (x == 0.0) return 32'h0;
        m = (x < 0.0) ? -x : x;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        be = 8'(e + 127);
        fr = 23'($rtoi((m - 1.0) * 8388608.0));
        return {x < 0.0, be, fr};
    endfunction

    // Behavioural MAC: exact for the small operand set used here.
    logic [31:0] y_pipe [MAC_LAT];
    always @(posedge clk) begin
        y_pipe[0] <= r2f(h2r(MAC_A) * h2r(MAC_B) + f2r(MAC_C));
        for (int i = 1; i < MAC_LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
    assign MAC_Y = y_pipe[MAC_LAT-1];

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] data;
    } res_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [32:0] jobq [NREQ][$];
    real         run_sum [NREQ];
    int          last_issue [NREQ];
    int          last_any;
    int          last_grant;
    res_t        res_q [$];
    bit          gap_en   = 1'b0;
    bit          hold_off = 1'b0;
    int          obs_g;
    logic [31:0] obs_c;
    logic [31:0] obs_y;
    logic [15:0] ops [6] = '{16'h3C00, 16'h3E00, 16'h4000, 16'hBC00, 16'h3800, 16'h4200};
    int          cont_exp [7] = '{0, 1, 2, 3, -1, -1, 0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREQ; r++) begin
            last_issue[r] = -1000;
            run_sum[r]    = 0.0;
        end
        last_any   = -1000;
        last_grant = NREQ - 1;
        res_q.delete();
    endtask

    function automatic bit model_idle();
        for (int r = 0; r < NREQ; r++) if (jobq[r].size() != 0) return 1'b0;
        return (res_q.size() == 0) && (cyc - last_any > MAC_LAT + 1);
    endfunction

    task automatic push_elem(input int r, input logic [15:0] a, input logic [15:0] b, input bit last);
        jobq[r].push_back({last, a, b});
    endtask

    task automatic add_rand_job(input int r, input int len);
        for (int i = 0; i < len; i++)
            push_elem(r, ops[$urandom_range(5)], ops[$urandom_range(5)], i == len - 1);
    endtask

    // One clock cycle: drive, predict from the streaming rules, compare, then commit the model.
    task automatic step(input bit rst);
        int          eg;
        int          idx;
        logic [NREQ-1:0] er;
        logic [32:0] e;
        @(negedge clk);
        RESET = rst;
        for (int r = 0; r < NREQ; r++) begin
            if (!hold_off && jobq[r].size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
                e = jobq[r][0];
                REQ_VALID[r]       = 1'b1;
                REQ_LAST[r]        = e[32];
                REQ_A[16*r +: 16]  = e[31:16];
                REQ_B[16*r +: 16]  = e[15:0];
            end else begin
                REQ_VALID[r]       = 1'b0;
                REQ_LAST[r]        = 1'($urandom_range(1));
                REQ_A[16*r +: 16]  = 16'($urandom);
                REQ_B[16*r +: 16]  = 16'($urandom);
            end
        end
        #1;
        eg = -1;
        if (!rst) begin
            for (int i = 1; i <= NREQ; i++) begin
                idx = (last_grant + i) % NREQ;
                if (eg < 0 && REQ_VALID[idx] && cyc >= last_issue[idx] + MAC_LAT) eg = idx;
            end
        end
        er = (eg >= 0) ? (NREQ'(1) << eg) : '0;
        obs_g = -1;
        for (int r = 0; r < NREQ; r++) if (REQ_READY[r]) obs_g = r;
        obs_c = MAC_C;
        obs_y = MAC_Y;

        check_eq("req_ready", 64'(REQ_READY), 64'(er));
        if (eg >= 0) begin
            e = jobq[eg][0];
            check_eq("mac_ab", 64'({MAC_A, MAC_B}), 64'(e[31:0]));
            check_eq("mac_c", 64'(MAC_C), 64'(r2f(run_sum[eg])));
        end else begin
            check_eq("mac_idle", 64'({MAC_A, MAC_B, MAC_C}), 64'h0);
        end
        if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
            check_eq("res_valid", 64'(RES_VALID), 64'h1);
            check_eq("res_id", 64'(RES_ID), 64'(res_q[0].id));
            check_eq("res_data", 64'(RES_DATA), 64'(res_q[0].data));
            void'(res_q.pop_front());
        end else begin
            check_eq("res_valid_idle", 64'(RES_VALID), 64'h0);
        end
        check_eq("busy", 64'(BUSY), 64'(cyc - last_any >= 1 && cyc - last_any <= MAC_LAT));

        if (rst) begin
            model_reset();
        end else if (eg >= 0) begin
            void'(jobq[eg].pop_front());
            run_sum[eg]    = run_sum[eg] + h2r(e[31:16]) * h2r(e[15:0]);
            last_issue[eg] = cyc;
            last_any       = cyc;
            last_grant     = eg;
            if (e[32]) begin
                res_q.push_back('{cyc + MAC_LAT + 1, eg, r2f(run_sum[eg])});
                run_sum[eg] = 0.0;
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while (!model_idle() && n < max_cyc) begin
            step(1'b0);
            n++;
        end
        check_eq("drain", 64'(model_idle()), 64'h1);
    endtask

    initial begin
        int prev;
        int rep;
        int n;
        RESET     = 1'b1;
        REQ_VALID = '1;
        REQ_A     = '0;
        REQ_B     = '0;
        REQ_LAST  = '0;
        model_reset();
        @(negedge clk);
        #1;
        check_eq("ready_in_reset", 64'(REQ_READY), 64'h0);
        REQ_VALID = '0;
        @(negedge clk);

        step(1'b0);
        check_eq("rst_res_id", 64'(RES_ID), 64'h0);
        check_eq("rst_res_data", 64'(RES_DATA), 64'h0);

        // Single three-element job on requester 0: 1.0*2.0 three times.
        for (int i = 0; i < 3; i++) push_elem(0, 16'h3C00, 16'h4000, i == 2);
        run_until_idle(100);

        // One-element job on requester 2, then a fresh job on the same requester.
        push_elem(2, 16'h3E00, 16'h4000, 1'b1);
        push_elem(2, 16'h3C00, 16'h3C00, 1'b1);
        run_until_idle(100);

        // Contention from a known pointer.
        step(1'b1);
        for (int r = 0; r < NREQ; r++) add_rand_job(r, 8);
        for (int k = 0; k < 7; k++) begin
            step(1'b0);
            check_eq($sformatf("cont_gnt%0d", k), 64'(obs_g), 64'(cont_exp[k]));
        end
        check_eq("cont_bypass_c", 64'(obs_c), 64'(obs_y));
        run_until_idle(400);

        // Fairness between requesters 1 and 3.
        add_rand_job(1, 10);
        add_rand_job(3, 10);
        prev = -1;
        rep  = 0;
        n    = 0;
        while (!model_idle() && n < 500) begin
            step(1'b0);
            if (obs_g >= 0) begin
                if (obs_g == prev) rep++;
                prev = obs_g;
            end
            n++;
        end
        check_eq("fair_alternate", 64'(rep), 64'h0);
        check_eq("fair_drain", 64'(model_idle()), 64'h1);

        // Reset with three elements in flight.
        for (int r = 0; r < 3; r++) add_rand_job(r, 6);
        repeat (3) step(1'b0);
        step(1'b1);
        hold_off = 1'b1;
        repeat (MAC_LAT) step(1'b0);
        hold_off = 1'b0;
        step(1'b0);
        check_eq("rst_first_gnt", 64'(obs_g), 64'h0);
        check_eq("rst_first_c", 64'(obs_c), 64'h0);
        run_until_idle(400);

        // Back-to-back jobs on requester 1: 2.0 then 1.0.
        push_elem(1, 16'h3C00, 16'h4000, 1'b1);
        push_elem(1, 16'h3C00, 16'h3C00, 1'b1);
        run_until_idle(100);

        // Random jobs with random valid gaps.
        gap_en = 1'b1;
        repeat (40) add_rand_job($urandom_range(NREQ - 1), $urandom_range(5, 1));
        run_until_idle(4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
